par8_rx_fifo: RTL and testbench
===============================

PAR8_RX_FIFO -- requirements
Module: par8_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, number of byte entries; a power of two, at least 4.
REQ-002 The block SHALL have parameter ALMOST_FULL, default 12, level at or above which bus_busy asserts; 1 to DEPTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rxd_data, input, 8 bits: byte from the parallel-bus receiver.
REQ-006 The block SHALL have port rxd_data_ready, input, 1 bit: one-cycle strobe marking rxd_data as valid.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous clear of the FIFO contents.
REQ-008 The block SHALL have port out_data, output, 8 bits: head byte to the command parser.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid byte.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the parser consumes the head byte when out_valid is high.
REQ-011 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-012 The block SHALL have port bus_busy, output, 1 bit: flow-control flag to the RPi master.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag for a dropped byte.
REQ-014 The block SHALL have port rx_count, output, 16 bits: count of accepted bytes (see Configuration).

Function
REQ-015 The FIFO SHALL be first-word-fall-through: out_data equals the oldest stored byte whenever out_valid=1.
REQ-016 A write SHALL occur on a cycle where rxd_data_ready=1 and either level<DEPTH or a read occurs in the same cycle.
REQ-017 A read SHALL occur on a cycle where out_valid=1 and out_ready=1.
REQ-018 Latency SHALL be 1: a byte written into an empty FIFO at edge N appears with out_valid=1 after edge N, with no combinational bypass.
REQ-019 Simultaneous read and write SHALL leave level unchanged, including when the FIFO is full (the write is accepted) and when it holds one entry (the new byte becomes the head after the edge).
REQ-020 With rxd_data_ready=1, level=DEPTH and no read, the byte SHALL be dropped, the contents SHALL be unchanged, and overflow SHALL set and hold until reset or flush.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH, and full and empty SHALL be distinguished by level alone.
REQ-022 out_valid SHALL equal (level!=0), and out_ready SHALL be ignored while out_valid=0.
REQ-023 bus_busy SHALL equal (level>=ALMOST_FULL), decoded from the registered level with no extra delay.
REQ-024 flush=1 SHALL, at the next edge, set level=0 and both pointers to 0 and clear overflow. Flush has priority over a simultaneous write or read, and the bytes involved are discarded.
REQ-025 rx_count SHALL increment by 1 per accepted write, wrap from 65535 to 0, and be unaffected by flush.

Reset
REQ-026 While reset=0, asynchronously: level=0, pointers=0, out_valid=0, bus_busy=0, overflow=0, rx_count=0, out_data=8'h00.
REQ-027 Reset asserted mid-transfer SHALL discard all stored bytes. A rxd_data_ready on the first edge after release SHALL be accepted normally.
REQ-028 Storage RAM contents SHALL need no reset, and out_data SHALL read 8'h00 whenever level=0.

Configuration
REQ-029 Macro PAR8_RX_FIFO_STATS_EN SHALL control the rx_count counter.
- Defined: rx_count is implemented per REQ-025.
- Undefined: the counter is not built, and rx_count is tied to 16'h0000.
- All other behaviour is identical in both builds.

Verification
REQ-030 After reset, write 8'hA5 (out_ready=0): out_valid=1 one cycle later, out_data=8'hA5, level=1.
REQ-031 Write 16 bytes 0x00..0x0F with out_ready=0, then send a 17th byte 0xFF:
- bus_busy=1 once level reaches 12.
- level=16 and overflow=1 after the 17th byte.
- Draining yields 0x00..0x0F in order, then out_valid=0.
REQ-032 Full FIFO, with rxd_data_ready=1 (data 0x55) and out_ready=1 in the same cycle: level stays 16, overflow stays 0, and 0x55 is read last.
REQ-033 Run 40 bytes with continuous write and read at level 1: pointers wrap twice, output order matches, level never exceeds 2, and rx_count=40 when the macro is defined (0 when undefined).
REQ-034 Assert flush with level=5 and a concurrent write: the next cycle shows level=0, out_valid=0, overflow=0, and rx_count unchanged.
REQ-035 Drop reset to 0 with level=7 mid-stream: all outputs go to their reset values without waiting for a clock edge. After release, a write of 0x3C is output first.

Source files
------------

// File: rtl/par8_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : par8_rx_fifo
// Description : First-word-fall-through byte FIFO between the parallel-bus
//               receiver and the command parser. It provides an almost-full
//               flow-control flag, a sticky overflow flag and an optional
//               accepted-byte counter.
// Options     : PAR8_RX_FIFO_STATS_EN - when defined, rx_count counts accepted
//               bytes. When undefined, rx_count is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module par8_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rxd_data,
    input  logic                   rxd_data_ready,
    input  logic                   flush,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   bus_busy,
    output logic                   overflow,
    output logic [15:0]            rx_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam logic [c_LW-1:0] c_FULL_LVL = c_LW'(DEPTH);
    localparam logic [c_LW-1:0] c_AF_LVL   = c_LW'(ALMOST_FULL);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
    localparam logic [c_LW-1:0] c_LVL_ONE  = c_LW'(1);

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_level;
    logic            r_overflow;

    logic w_empty;
    logic w_full;
    logic w_rd;
    logic w_wr;
    logic w_drop;

    // Full and empty come from the occupancy count alone, so the pointers
    // can wrap freely without an extra wrap bit.
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_FULL_LVL);
    assign w_rd    = !w_empty && out_ready && !flush;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign w_wr    = rxd_data_ready && (!w_full || (!w_empty && out_ready)) && !flush;
    assign w_drop  = rxd_data_ready && w_full && !out_ready && !flush;

    // Byte storage. It needs no reset because the read side masks it to zero
    // while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= rxd_data;
        end
    end

    // Pointers, occupancy and sticky overflow. Flush outranks any traffic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_wr && !w_rd) begin
                r_level <= r_level + c_LVL_ONE;
            end else if (w_rd && !w_wr) begin
                r_level <= r_level - c_LVL_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // The head byte falls through from storage. There is no path from
    // rxd_data, so a new byte appears one edge after it is written.
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign level     = r_level;
    assign bus_busy  = (r_level >= c_AF_LVL);
    assign overflow  = r_overflow;

`ifdef PAR8_RX_FIFO_STATS_EN
    logic [15:0] r_rx_count;

    // Count of accepted bytes. Flush does not clear it, and it wraps
    // naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_count <= 16'h0000;
        end else if (w_wr) begin
            r_rx_count <= r_rx_count + 16'd1;
        end
    end

    assign rx_count = r_rx_count;
`else
    assign rx_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_par8_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_par8_rx_fifo
// Description : Directed self-checking bench for par8_rx_fifo. A queue-based
//               model of the FIFO is compared against the outputs on every
//               falling edge. Literal expectations are also checked at
//               key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_par8_rx_fifo;

    localparam int DEPTH       = 16;
    localparam int ALMOST_FULL = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rxd_data = 8'h00;
    logic        rxd_data_ready = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  level;
    logic        bus_busy;
    logic        overflow;
    logic [15:0] rx_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [7:0] m_q[$];
    bit         m_ovf = 1'b0;
    int         m_cnt = 0;

    par8_rx_fifo #(
        .DEPTH       (DEPTH),
        .ALMOST_FULL (ALMOST_FULL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rxd_data       (rxd_data),
        .rxd_data_ready (rxd_data_ready),
        .flush          (flush),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .level          (level),
        .bus_busy       (bus_busy),
        .overflow       (overflow),
        .rx_count       (rx_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int exp_count(input int n);
`ifdef PAR8_RX_FIFO_STATS_EN
        return n % 65536;
`else
        return 0;
`endif
    endfunction

    // Compare the outputs against the model every cycle while out of reset.
    always @(negedge clk) begin
        if (reset) begin
            check("out_valid", int'(out_valid), int'(m_q.size() != 0));
            check("out_data",  int'(out_data),  (m_q.size() != 0) ? int'(m_q[0]) : 0);
            check("level",     int'(level),     m_q.size());
            check("bus_busy",  int'(bus_busy),  int'(m_q.size() >= ALMOST_FULL));
            check("overflow",  int'(overflow),  int'(m_ovf));
            check("rx_count",  int'(rx_count),  exp_count(m_cnt));
        end
    end

    // Drive one cycle of stimulus, then advance the model across the edge.
    task automatic step(input bit rdy, input logic [7:0] d, input bit ordy, input bit fl);
        bit rd;
        bit wr;
        rxd_data_ready = rdy;
        rxd_data       = d;
        out_ready      = ordy;
        flush          = fl;
        @(posedge clk);
        rd = (m_q.size() != 0) && ordy;
        wr = rdy && ((m_q.size() < DEPTH) || rd);
        if (fl) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (rd) void'(m_q.pop_front());
            if (wr) begin
                m_q.push_back(d);
                m_cnt++;
            end
            if (rdy && !wr) m_ovf = 1'b1;
        end
        #1;
        rxd_data_ready = 1'b0;
        out_ready      = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_data"},  int'(out_data),  0);
        check({tag, "_level"}, int'(level),     0);
        check({tag, "_busy"},  int'(bus_busy),  0);
        check({tag, "_ovf"},   int'(overflow),  0);
        check({tag, "_cnt"},   int'(rx_count),  0);
    endtask

    initial begin
        // Reset state.
        #2;
        check_reset_values("rst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Single byte with one-cycle latency.
        step(1, 8'hA5, 0, 0);
        check("lat_valid", int'(out_valid), 1);
        check("lat_data",  int'(out_data),  8'hA5);
        check("lat_level", int'(level),     1);
        step(0, 8'h00, 1, 0);
        check("lat_empty", int'(out_valid), 0);

        // Fill to full, observe almost-full threshold, then overflow.
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i), 0, 0);
            if (i == 10) check("busy_below", int'(bus_busy), 0);
            if (i == 11) check("busy_at12",  int'(bus_busy), 1);
        end
        step(1, 8'hFF, 0, 0);
        check("full_level", int'(level),    16);
        check("full_ovf",   int'(overflow), 1);
        for (int i = 0; i < 16; i++) begin
            check("drain_order", int'(out_data), i);
            step(0, 8'h00, 1, 0);
        end
        check("drain_empty", int'(out_valid), 0);
        check("ovf_sticky",  int'(overflow),  1);
        step(0, 8'h00, 0, 1);
        check("flush_ovf", int'(overflow), 0);

        // A full FIFO accepts a write when a read happens on the same edge.
        for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0);
        step(1, 8'h55, 1, 0);
        check("rw_full_level", int'(level),    16);
        check("rw_full_ovf",   int'(overflow), 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("rw_full_last", int'(out_data), 8'h55);
            step(0, 8'h00, 1, 0);
        end

        // Fresh reset, then 40 bytes streamed at level 1 (pointers wrap twice).
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        step(1, 8'h80, 0, 0);
        for (int i = 1; i < 40; i++) begin
            step(1, 8'(8'h80 + i), 1, 0);
            check("stream_lvl_le2", int'(level <= 2), 1);
        end
        check("stream_head", int'(out_data), 8'hA7);
        step(0, 8'h00, 1, 0);
        check("stream_cnt", int'(rx_count), exp_count(40));

        // Flush at level 5 with a concurrent write and overflow set.
        for (int i = 0; i < 16; i++) step(1, 8'(8'hC0 + i), 0, 0);
        step(1, 8'hEE, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 8'h00, 1, 0);
        check("pre_flush_level", int'(level),    5);
        check("pre_flush_ovf",   int'(overflow), 1);
        step(1, 8'h77, 1, 1);
        check("flush_level", int'(level),     0);
        check("flush_valid", int'(out_valid), 0);
        check("flush_ovf2",  int'(overflow),  0);
        check("flush_cnt",   int'(rx_count),  exp_count(56));

        // Asynchronous reset in the middle of the stream at level 7.
        for (int i = 0; i < 7; i++) step(1, 8'(8'h60 + i), 0, 0);
        check("pre_rst_level", int'(level), 7);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_reset_values("async");
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        step(1, 8'h3C, 0, 0);
        check("post_rst_data",  int'(out_data), 8'h3C);
        check("post_rst_level", int'(level),    1);
        check("post_rst_cnt",   int'(rx_count), exp_count(1));
        step(0, 8'h00, 1, 0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
